sprite_renderer: RTL and testbench

Pixel generator that turns the sprite positions produced by the game logic into an RGB pixel stream for the VGA output.
- Sits between the VGA timing generator and the DAC/output pins.
- Samples player, enemy and ball positions into shadow registers once per frame, so the image never tears.
- Resolves per-pixel sprite membership through a 2-stage pipeline.
- Delays hsync/vsync/visible by the same latency so they stay aligned with `rgb_o`.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/sprite_renderer_if.sv | 34 +++
 rtl/rect_hit.sv | 26 ++
 rtl/sprite_renderer.sv | 150 +++++++++++++++
 tb/tb_sprite_renderer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong video path: position widths, screen
// geometry, sprite sizes, default colours and the renderer latency.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

package pong_pkg;
  localparam int COLOR_W = 4;
  typedef logic [3*COLOR_W-1:0] rgb_t;

  localparam rgb_t BG_COLOR_DEF     = 12'h000;
  localparam rgb_t PADDLE_COLOR_DEF = 12'hFFF;
  localparam rgb_t BALL_COLOR_DEF   = 12'hF80;
  localparam rgb_t FIELD_COLOR_DEF  = 12'h888;

  // Cycles from pixel coordinates/syncs to rgb_o and the delayed syncs.
  localparam int RENDER_LATENCY = 2;

  localparam int SCREEN_H_RES  = 640;
  localparam int SCREEN_V_RES  = 480;
  localparam int SCREEN_BORDER = 10;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_HEIGHT = 60;
  localparam int BALL_SIDE     = 10;
endpackage

// File: rtl/sprite_renderer_if.sv
// Bundle of the renderer's pixel-stream, sprite-position and output signals.
// master = timing generator / game logic side, slave = sprite_renderer.
interface sprite_renderer_if #(
  parameter int COLOR_W = 4
);
  logic                   new_frame_i;
  logic [`X_POS_W-1:0]    pixel_x_i;
  logic [`Y_POS_W-1:0]    pixel_y_i;
  logic                   visible_i;
  logic                   hsync_i;
  logic                   vsync_i;
  logic [`X_POS_W-1:0]    player_x_i;
  logic [`X_POS_W-1:0]    enemy_x_i;
  logic [`X_POS_W-1:0]    ball_x_i;
  logic [`Y_POS_W-1:0]    player_y_i;
  logic [`Y_POS_W-1:0]    enemy_y_i;
  logic [`Y_POS_W-1:0]    ball_y_i;
  logic [3*COLOR_W-1:0]   rgb_o;
  logic                   hsync_o;
  logic                   vsync_o;
  logic                   visible_o;

  modport master (
    output new_frame_i, pixel_x_i, pixel_y_i, visible_i, hsync_i, vsync_i,
           player_x_i, enemy_x_i, ball_x_i, player_y_i, enemy_y_i, ball_y_i,
    input  rgb_o, hsync_o, vsync_o, visible_o
  );

  modport slave (
    input  new_frame_i, pixel_x_i, pixel_y_i, visible_i, hsync_i, vsync_i,
           player_x_i, enemy_x_i, ball_x_i, player_y_i, enemy_y_i, ball_y_i,
    output rgb_o, hsync_o, vsync_o, visible_o
  );
endinterface

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test with half-open ranges. The far
// edges are computed one bit wider so rectangles near the top of the
// coordinate range never wrap around to zero.
module rect_hit #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int W  = 10,
  parameter int H  = 10
) (
  input  logic [XW-1:0] px_i,
  input  logic [YW-1:0] py_i,
  input  logic [XW-1:0] left_i,
  input  logic [YW-1:0] top_i,
  output logic          hit_o
);
  logic [XW:0] right;
  logic [YW:0] bottom;

  // Widened bounds and the four edge compares.
  always_comb begin
    right  = {1'b0, left_i} + (XW+1)'(W);
    bottom = {1'b0, top_i}  + (YW+1)'(H);
    hit_o  = (px_i >= left_i) && ({1'b0, px_i} < right) &&
             (py_i >= top_i)  && ({1'b0, py_i} < bottom);
  end
endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel generator: per-frame shadow positions, registered hit
// flags (stage 1), registered priority colour mux (stage 2). Syncs and
// visible travel alongside so they stay aligned with rgb_o.
// Optional feature: define CENTER_NET_EN to draw the dashed centre net.
module sprite_renderer
  import pong_pkg::*;
#(
  parameter int                   COLOR_W      = 4,
  parameter logic [3*COLOR_W-1:0] BG_COLOR     = 12'h000,
  parameter logic [3*COLOR_W-1:0] PADDLE_COLOR = 12'hFFF,
  parameter logic [3*COLOR_W-1:0] BALL_COLOR   = 12'hF80,
  parameter logic [3*COLOR_W-1:0] FIELD_COLOR  = 12'h888,
  parameter logic                 SYNC_IDLE    = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  sprite_renderer_if.slave  bus
);
  localparam int XW = `X_POS_W;
  localparam int YW = `Y_POS_W;
  localparam logic [YW:0] BORDER_TOP = (YW+1)'(SCREEN_BORDER);
  localparam logic [YW:0] BORDER_BOT = (YW+1)'(SCREEN_V_RES - SCREEN_BORDER);

  logic [XW-1:0] player_x_q, enemy_x_q, ball_x_q, player_x_d, enemy_x_d, ball_x_d;
  logic [YW-1:0] player_y_q, enemy_y_q, ball_y_q, player_y_d, enemy_y_d, ball_y_d;

  logic ball_hit, player_hit, enemy_hit, net_hit, border_hit;
  logic ball_p1_q, player_p1_q, enemy_p1_q, net_p1_q, border_p1_q;
  logic vld_p1_q, hs_p1_q, vs_p1_q;
  logic [3*COLOR_W-1:0] rgb_p2_q;
  logic vld_p2_q, hs_p2_q, vs_p2_q;

  function automatic logic [3*COLOR_W-1:0] pick_color(
    input logic vis, input logic ball, input logic player,
    input logic enemy, input logic field
  );
    if (!vis)                 return '0;
    if (ball)                 return BALL_COLOR;
    if (player || enemy)      return PADDLE_COLOR;
    if (field)                return FIELD_COLOR;
    return BG_COLOR;
  endfunction

  // Shadow positions reload only on the frame pulse.
  always_comb begin
    player_x_d = player_x_q;
    enemy_x_d  = enemy_x_q;
    ball_x_d   = ball_x_q;
    player_y_d = player_y_q;
    enemy_y_d  = enemy_y_q;
    ball_y_d   = ball_y_q;
    if (bus.new_frame_i) begin
      player_x_d = bus.player_x_i;
      enemy_x_d  = bus.enemy_x_i;
      ball_x_d   = bus.ball_x_i;
      player_y_d = bus.player_y_i;
      enemy_y_d  = bus.enemy_y_i;
      ball_y_d   = bus.ball_y_i;
    end
  end

  // Shadow register update; reset has priority over the frame pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      player_x_q <= '0;
      enemy_x_q  <= '0;
      ball_x_q   <= '0;
      player_y_q <= '0;
      enemy_y_q  <= '0;
      ball_y_q   <= '0;
    end else begin
      player_x_q <= player_x_d;
      enemy_x_q  <= enemy_x_d;
      ball_x_q   <= ball_x_d;
      player_y_q <= player_y_d;
      enemy_y_q  <= enemy_y_d;
      ball_y_q   <= ball_y_d;
    end
  end

  rect_hit #(.XW(XW), .YW(YW), .W(BALL_SIDE), .H(BALL_SIDE)) u_ball_hit (
    .px_i(bus.pixel_x_i), .py_i(bus.pixel_y_i),
    .left_i(ball_x_q), .top_i(ball_y_q), .hit_o(ball_hit)
  );
  rect_hit #(.XW(XW), .YW(YW), .W(PADDLE_WIDTH), .H(PADDLE_HEIGHT)) u_player_hit (
    .px_i(bus.pixel_x_i), .py_i(bus.pixel_y_i),
    .left_i(player_x_q), .top_i(player_y_q), .hit_o(player_hit)
  );
  rect_hit #(.XW(XW), .YW(YW), .W(PADDLE_WIDTH), .H(PADDLE_HEIGHT)) u_enemy_hit (
    .px_i(bus.pixel_x_i), .py_i(bus.pixel_y_i),
    .left_i(enemy_x_q), .top_i(enemy_y_q), .hit_o(enemy_hit)
  );

  assign border_hit = ({1'b0, bus.pixel_y_i} < BORDER_TOP) ||
                      ({1'b0, bus.pixel_y_i} >= BORDER_BOT);

`ifdef CENTER_NET_EN
  localparam logic [XW-1:0] NET_X0 = XW'(SCREEN_H_RES/2 - 1);
  localparam logic [XW-1:0] NET_X1 = XW'(SCREEN_H_RES/2 + 1);
  // Two columns wide, 8 rows on / 8 rows off.
  assign net_hit = (bus.pixel_x_i >= NET_X0) && (bus.pixel_x_i < NET_X1) &&
                   !bus.pixel_y_i[3];
`else
  assign net_hit = 1'b0;
`endif

  // ---- stage 1: register hit flags and the pixel's control signals ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ball_p1_q   <= 1'b0;
      player_p1_q <= 1'b0;
      enemy_p1_q  <= 1'b0;
      net_p1_q    <= 1'b0;
      border_p1_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      hs_p1_q     <= SYNC_IDLE;
      vs_p1_q     <= SYNC_IDLE;
    end else begin
      ball_p1_q   <= ball_hit;
      player_p1_q <= player_hit;
      enemy_p1_q  <= enemy_hit;
      net_p1_q    <= net_hit;
      border_p1_q <= border_hit;
      vld_p1_q    <= bus.visible_i;
      hs_p1_q     <= bus.hsync_i;
      vs_p1_q     <= bus.vsync_i;
    end
  end

  // ---- stage 2: priority colour mux and aligned syncs ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_p2_q <= '0;
      vld_p2_q <= 1'b0;
      hs_p2_q  <= SYNC_IDLE;
      vs_p2_q  <= SYNC_IDLE;
    end else begin
      rgb_p2_q <= pick_color(vld_p1_q, ball_p1_q, player_p1_q, enemy_p1_q,
                             net_p1_q || border_p1_q);
      vld_p2_q <= vld_p1_q;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign bus.rgb_o     = rgb_p2_q;
  assign bus.visible_o = vld_p2_q;
  assign bus.hsync_o   = hs_p2_q;
  assign bus.vsync_o   = vs_p2_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer (640x480, border 10, paddle 10x60,
// ball 10). Stimulus pushes the expected output with the cycle it is due;
// a monitor pops and compares on the falling edge.
module tb_sprite_renderer;
  localparam logic [11:0] BG  = 12'h000;
  localparam logic [11:0] PAD = 12'hFFF;
  localparam logic [11:0] BAL = 12'hF80;
  localparam logic [11:0] FLD = 12'h888;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_renderer_if bus_if ();

  sprite_renderer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vis;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input int x, input int y, input bit vis, input bit hs,
                       input bit vs, input bit nf, input bit r);
    @(negedge clk);
    rst                 = r;
    bus_if.new_frame_i  = nf;
    bus_if.pixel_x_i    = 10'(x);
    bus_if.pixel_y_i    = 10'(y);
    bus_if.visible_i    = vis;
    bus_if.hsync_i      = hs;
    bus_if.vsync_i      = vs;
  endtask

  task automatic pix(input string nm, input int x, input int y, input logic [11:0] e,
                     input bit vis = 1'b1, input bit hs = 1'b1, input bit vs = 1'b1,
                     input bit nf = 1'b0);
    exp_t t;
    drive(x, y, vis, hs, vs, nf, 1'b0);
    t.due = cyc + 2; t.rgb = e; t.hs = hs; t.vs = vs; t.vis = vis; t.name = nm;
    q.push_back(t);
  endtask

  // Reset cycle with a hit pixel, sync low and frame pulse on the inputs.
  task automatic rst_cyc(input string nm, input int x, input int y);
    exp_t t;
    drive(x, y, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    t.due = cyc + 1; t.rgb = BG; t.hs = 1'b1; t.vs = 1'b1; t.vis = 1'b0; t.name = nm;
    q.push_back(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_pos(input int bx, input int by, input int px, input int py,
                         input int ex, input int ey);
    bus_if.ball_x_i   = 10'(bx);
    bus_if.ball_y_i   = 10'(by);
    bus_if.player_x_i = 10'(px);
    bus_if.player_y_i = 10'(py);
    bus_if.enemy_x_i  = 10'(ex);
    bus_if.enemy_y_i  = 10'(ey);
  endtask

  // Monitor: compare every entry that falls due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.due != cyc || bus_if.rgb_o !== e.rgb || bus_if.hsync_o !== e.hs ||
            bus_if.vsync_o !== e.vs || bus_if.visible_o !== e.vis) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d rgb got %h want %h hs got %b want %b vs got %b want %b vis got %b want %b",
                   e.name, cyc, e.due, bus_if.rgb_o, e.rgb, bus_if.hsync_o, e.hs,
                   bus_if.vsync_o, e.vs, bus_if.visible_o, e.vis);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.new_frame_i = 1'b0;
    bus_if.pixel_x_i = '0; bus_if.pixel_y_i = '0;
    bus_if.visible_i = 1'b0; bus_if.hsync_i = 1'b1; bus_if.vsync_i = 1'b1;
    set_pos(100, 200, 620, 210, 20, 300);

    // Reset held 3 cycles, with new_frame_i asserted too (reset wins).
    rst_cyc("reset0", 105, 205);
    rst_cyc("reset1", 105, 205);
    rst_cyc("reset2", 105, 205);
    idle(2);

    // Shadows still 0: nothing at the input positions yet.
    pix("preframe_ball", 105, 205, BG);
    pix("preframe_player", 625, 240, BG);

    // Frame pulse on a blanked pixel; syncs low must come through delayed.
    pix("nf_blank", 0, 0, BG, 1'b0, 1'b0, 1'b0, 1'b1);

    // Ball horizontal edges on row 205.
    for (int x = 99; x <= 110; x++)
      pix($sformatf("ball_row205_x%0d", x), x, 205, (x >= 100 && x <= 109) ? BAL : BG);
    pix("ball_top_edge", 105, 199, BG);
    pix("ball_bot_in", 105, 209, BAL);
    pix("ball_bot_out", 105, 210, BG);

    // Ball overlapping the player paddle.
    set_pos(620, 240, 620, 210, 20, 300);
    pix("nf_prio", 0, 0, BG, 1'b0, 1'b1, 1'b1, 1'b1);
    pix("prio_overlap", 625, 245, BAL);
    pix("prio_last_ball_row", 629, 249, BAL);
    pix("prio_below_ball", 625, 250, PAD);
    pix("prio_above_ball", 625, 239, PAD);
    pix("paddle_top_left", 620, 210, PAD);
    pix("paddle_bot_right", 629, 269, PAD);
    pix("paddle_below", 629, 270, BG);
    pix("paddle_right_out", 630, 245, BG);
    pix("paddle_left_out", 619, 245, BG);
    pix("enemy_body", 25, 305, PAD);
    pix("enemy_above", 25, 299, BG);

    // Frame latch: input change without pulse is ignored until the pulse.
    set_pos(100, 200, 620, 210, 20, 300);
    pix("nf_latch", 0, 0, BG, 1'b0, 1'b1, 1'b1, 1'b1);
    pix("latch_start", 105, 205, BAL);
    bus_if.ball_x_i = 10'd300;
    pix("latch_old_pos", 105, 205, BAL);
    pix("latch_new_not_yet", 305, 205, BG);
    pix("latch_pulse_visible", 105, 205, BAL, 1'b1, 1'b1, 1'b1, 1'b1);
    pix("latch_new_pos", 305, 205, BAL);
    pix("latch_old_gone", 105, 205, BG);

    // Border band and blanking.
    pix("border_row5", 50, 5, FLD);
    pix("border_row475", 50, 475, FLD);
    pix("border_row9", 50, 9, FLD);
    pix("border_row10", 50, 10, BG);
    pix("border_row469", 50, 469, BG);
    pix("border_row470", 50, 470, FLD);
    pix("blank_on_ball", 305, 205, BG, 1'b0, 1'b0, 1'b1);

`ifdef CENTER_NET_EN
    for (int y = 0; y < 16; y++)
      pix($sformatf("net_319_%0d", y), 319, y, (y < 8) ? FLD : ((y < 10) ? FLD : BG));
    pix("net_dash_on", 319, 20, FLD);
    pix("net_dash_off", 319, 24, BG);
    pix("net_col320", 320, 20, FLD);
    pix("net_col318", 318, 20, BG);
    pix("net_col321", 321, 20, BG);
`else
    pix("no_net_319_100", 319, 100, BG);
    pix("no_net_320_16", 320, 16, BG);
`endif

    // Mid-frame reset: outputs clear next cycle, shadows back to 0.
    idle(2);
    rst_cyc("midreset", 305, 205);
    idle(2);
    pix("post_reset_ball_gone", 305, 205, BG);
    pix("post_reset_paddle_gone", 625, 245, BG);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
